// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, RISC-V funct3 width codes
// and the natural-alignment helper.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        DONE,
        ERR
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Clears the low offset bits that a halfword/word access may not use.
    function automatic logic [1:0] align_offset(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_H, F3_HU: align_offset = {off[1], 1'b0};
            F3_W:        align_offset = 2'b00;
            default:     align_offset = off;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane datapath: extracts and extends a load lane from a memory word, and
// merges store data into a previously read word for sub-word stores.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] load_val,
    output logic [31:0] merge_val
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rd_word[{offset, 3'b000} +: 8];
        lane_h = rd_word[{offset[1], 4'b0000} +: 16];
        case (funct3)
            F3_B:    load_val = {{24{lane_b[7]}}, lane_b};
            F3_BU:   load_val = {24'h0, lane_b};
            F3_H:    load_val = {{16{lane_h[15]}}, lane_h};
            F3_HU:   load_val = {16'h0, lane_h};
            default: load_val = rd_word;
        endcase
    end

    // Full-word stores bypass the read word entirely.
    always_comb begin
        merge_val = old_word;
        case (funct3)
            F3_B:    merge_val[{offset, 3'b000} +: 8]     = wdata[7:0];
            F3_H:    merge_val[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            default: merge_val = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle RISC-V load/store unit (read-modify-write for SB/SH).
// Define LSU_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses instead of aligning them.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic [31:0] mem_A,
    output logic [31:0] mem_WD,
    output logic        mem_WE,
    input  logic [31:0] mem_RD
);

    state_t      state;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;
    logic        wr_q;
    logic        illegal;
    logic [1:0]  off;
    logic [31:0] load_val;
    logic [31:0] merge_val;

    always_comb begin
        illegal = 1'b0;
        case (funct3)
            F3_B, F3_H, F3_W: illegal = 1'b0;
            F3_BU, F3_HU:     illegal = we;
            default:          illegal = 1'b1;
        endcase
`ifdef LSU_MISALIGN_TRAP_EN
        if ((funct3 == F3_H || funct3 == F3_HU) && addr[0])
            illegal = 1'b1;
        if (funct3 == F3_W && addr[1:0] != 2'b00)
            illegal = 1'b1;
`endif
    end

    assign off    = align_offset(f3_q, addr_q[1:0]);
    assign mem_A  = {addr_q[31:2], 2'b00};
    assign mem_WD = merge_val;
    // Gated by rst so a reset landing in WRITE suppresses the write on that edge.
    assign mem_WE = wr_q & ~rst;

    lsu_align u_align (
        .rd_word  (mem_RD),
        .old_word (word_q),
        .wdata    (wdata_q),
        .offset   (off),
        .funct3   (f3_q),
        .load_val (load_val),
        .merge_val(merge_val)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            wr_q  <= 1'b0;
            rdata <= 32'h0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            wr_q <= 1'b0;
            case (state)
                IDLE: if (req) begin
                    we_q    <= we;
                    f3_q    <= funct3;
                    addr_q  <= addr;
                    wdata_q <= wdata;
                    busy    <= 1'b1;
                    if (illegal) begin
                        state <= ERR;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else if (we && funct3 == F3_W) begin
                        state <= WRITE;
                        wr_q  <= 1'b1;
                    end else begin
                        state <= READ;
                    end
                end
                READ: begin
                    word_q <= mem_RD;
                    if (we_q) begin
                        state <= WRITE;
                        wr_q  <= 1'b1;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                        rdata <= load_val;
                    end
                end
                WRITE: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE, ERR: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit against a byte-addressed reference memory.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        busy, done, err, mem_WE;
    logic [31:0] rdata, mem_A, mem_WD, mem_RD;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3), .addr(addr),
        .wdata(wdata), .busy(busy), .done(done), .rdata(rdata), .err(err),
        .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
    );

    // Bench-side memory (4 KiB), loaded during reset through the init port.
    logic [31:0] mem [0:1023];
    logic        init_we = 1'b0;
    logic [9:0]  init_idx = 10'h0;
    logic [31:0] init_data = 32'h0;
    always @(posedge clk) begin
        if (init_we) mem[init_idx] <= init_data;
        else if (mem_WE) mem[mem_A[11:2]] <= mem_WD;
    end
    assign mem_RD = mem[mem_A[11:2]];

    logic [7:0] ref_mem [0:4095];
    logic [31:0] exp_rdata = 32'h0;

    typedef struct { logic e; logic [31:0] rd; } resp_t;
    typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
    resp_t rq[$];
    wr_t   wq[$];

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] ref_word(input int a);
        logic [31:0] w = 32'h0;
        for (int i = 0; i < 4; i++) w = w | (32'(ref_mem[(a & ~3) + i]) << (8 * i));
        return w;
    endfunction

    // Reference behaviour: decides legality, updates the byte memory and queues the
    // expected completion and write; returns the expected done latency.
    function automatic int model(input logic w, input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] d);
        bit illegal;
        int n, ea;
        logic [31:0] val;
        illegal = (f == 3'b011) || (f == 3'b110) || (f == 3'b111) ||
                  (w && (f == 3'b100 || f == 3'b101));
        n = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
`ifdef LSU_MISALIGN_TRAP_EN
        if (!illegal && (int'(a) % n) != 0) illegal = 1;
`endif
        ea = int'(a) - (int'(a) % n);
        if (illegal) begin
            rq.push_back('{1'b1, exp_rdata});
            return 1;
        end
        if (w) begin
            for (int i = 0; i < n; i++) ref_mem[ea + i] = 8'(d >> (8 * i));
            wq.push_back('{32'(ea & ~3), ref_word(ea)});
            rq.push_back('{1'b0, exp_rdata});
            return (n == 4) ? 2 : 3;
        end
        val = 32'h0;
        for (int i = 0; i < n; i++) val = val | (32'(ref_mem[ea + i]) << (8 * i));
        if (!f[2] && n < 4 && val[8 * n - 1]) val = val | (32'hFFFF_FFFF << (8 * n));
        exp_rdata = val;
        rq.push_back('{1'b0, exp_rdata});
        return 2;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT completes or writes.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                if (rq.size() == 0) check("spurious_done", {31'h0, done}, 32'h0);
                else begin
                    resp_t r;
                    r = rq.pop_front();
                    check("err", {31'h0, err}, {31'h0, r.e});
                    check("rdata", rdata, r.rd);
                end
            end
            if (mem_WE) begin
                if (wq.size() == 0) check("spurious_write", {31'h0, mem_WE}, 32'h0);
                else begin
                    wr_t x;
                    x = wq.pop_front();
                    check("mem_A", mem_A, x.a);
                    check("mem_WD", mem_WD, x.d);
                end
            end
        end
    end

    task automatic op(input logic w, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] d, input bit hold_req);
        int lat, cyc;
        lat = model(w, f, a, d);
        @(negedge clk);
        req = 1'b1; we = w; funct3 = f; addr = a; wdata = d;
        @(posedge clk);
        #1;
        req = hold_req;
        if (hold_req) begin
            we = $urandom_range(0, 1); funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
        end
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check("busy", {31'h0, busy}, 32'h1);
        end while (!done && cyc < 8);
        req = 1'b0;
        check("latency", 32'(cyc), 32'(lat));
    endtask

    // SB to 0x100 aborted by reset in READ (stage 0) or WRITE (stage 1).
    task automatic reset_abort(input int stage);
        @(negedge clk);
        req = 1'b1; we = 1'b1; funct3 = F3_B; addr = 32'h100; wdata = 32'h55;
        @(posedge clk);
        #1;
        req = 1'b0;
        if (stage == 1) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_done", {31'h0, done}, 32'h0);
        check("abort_we", {31'h0, mem_WE}, 32'h0);
        check("abort_rdata", rdata, 32'h0);
        exp_rdata = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        check("abort_word", mem[32'h100 >> 2], ref_word(32'h100));
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            logic [31:0] v;
            v = (i == 32'h100 / 4) ? 32'h8899_AABB : $urandom;
            for (int b = 0; b < 4; b++) ref_mem[4 * i + b] = 8'(v >> (8 * b));
            @(negedge clk);
            init_we = 1'b1; init_idx = 10'(i); init_data = v;
        end
        @(negedge clk);
        init_we = 1'b0;
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        check("rst_we", {31'h0, mem_WE}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        rst = 1'b0;

        op(1'b0, F3_B,  32'h101, 32'h0, 1'b0);          // LB  -> FFFFFFAA
        op(1'b0, F3_HU, 32'h102, 32'h0, 1'b0);          // LHU -> 00008899
        op(1'b0, F3_W,  32'h102, 32'h0, 1'b0);          // LW misaligned
        op(1'b1, F3_B,  32'h102, 32'h12, 1'b0);         // SB  -> 8812AABB
        op(1'b1, F3_W,  32'h200, 32'hDEAD_BEEF, 1'b0);  // SW
        op(1'b0, F3_W,  32'h200, 32'h0, 1'b0);
        op(1'b1, F3_BU, 32'h200, 32'h0, 1'b0);          // illegal store width
        op(1'b0, 3'b011, 32'h200, 32'h0, 1'b0);         // illegal funct3
        reset_abort(0);
        reset_abort(1);
        op(1'b0, F3_W,  32'h100, 32'h0, 1'b0);

        for (int k = 0; k < 300; k++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 4095));
            if ($urandom_range(0, 1) == 1) a = a & ~32'h3;
            op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
               $urandom_range(0, 3) == 0);
        end

        repeat (3) @(negedge clk);
        check("resp_queue_empty", 32'(rq.size()), 32'h0);
        check("write_queue_empty", 32'(wq.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 req  input  1  start-access strobe from the core; sampled only in IDLE.
REQ-005 we  input  1  access type: 1 = store, 0 = load.
REQ-006 funct3  input  3  RISC-V width code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-007 addr  input  32  byte address.
REQ-008 wdata  input  32  store data, right-aligned.
REQ-009 busy  output  1  high in every non-IDLE state.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 rdata  output  32  sign- or zero-extended load result.
REQ-012 err  output  1  one-cycle error pulse, coincident with done.
REQ-013 mem_A  output  32  word address to memory; bits [1:0] always 00.
REQ-014 mem_WD  output  32  full-word write data to memory.
REQ-015 mem_WE  output  1  memory write enable; memory writes on the clk edge where mem_WE=1.
REQ-016 mem_RD  input  32  memory read data, combinationally valid for the current mem_A; little-endian byte lanes.

Function
REQ-017 The FSM SHALL have exactly these states: IDLE, READ, WRITE, DONE, ERR.
REQ-018 On req in IDLE, the block SHALL latch we, funct3, addr and wdata, and go to: ERR if the access is illegal; WRITE for SW; READ otherwise.
REQ-019 In READ, mem_A SHALL be {addr[31:2],2'b00} and mem_RD SHALL be captured into an internal word register; next state is WRITE for SB/SH and DONE for loads.
REQ-020 In WRITE, mem_WE SHALL be 1 for exactly one cycle. mem_WD is wdata for SW. For SB/SH it is the captured word with the addressed byte or halfword lane replaced by wdata[7:0] or wdata[15:0]. Next state is DONE.
REQ-021 In DONE, done SHALL be 1 for one cycle; for loads, rdata SHALL update on entry to DONE from the selected lane (offset addr[1:0]), sign-extended for LB/LH and zero-extended for LBU/LHU. Next state is IDLE.
REQ-022 Latency from the req-sampling edge: load and SW SHALL pulse done in the 2nd cycle; SB/SH SHALL pulse done in the 3rd cycle.
REQ-023 ERR SHALL assert done=1 and err=1 for one cycle, perform no memory write, leave rdata unchanged, and return to IDLE.
REQ-024 funct3 011, 110, 111, and store with funct3 100 or 101, SHALL be illegal in all configurations.
REQ-025 req SHALL be ignored while busy=1, and back-to-back req SHALL be accepted in the IDLE cycle following DONE or ERR.
REQ-026 rdata SHALL hold its value until the next successful load completes.
REQ-027 mem_WE SHALL be 0 in every state other than WRITE.

Reset
REQ-028 On rst, the state SHALL become IDLE and busy, done, err, mem_WE and rdata SHALL be 0 on the next cycle.
REQ-029 Reset SHALL override any state, and reset asserted during READ or WRITE SHALL abort the access with no memory write on that edge.

Configuration
REQ-030 Macro LSU_MISALIGN_TRAP_EN SHALL govern misalignment handling.
REQ-031 With the macro defined, LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=00, SHALL go to ERR.
REQ-032 Without the macro, the low address bits SHALL be forced to natural alignment (halfword: addr[0]=0; word: addr[1:0]=00), the access SHALL proceed normally, and err SHALL be asserted only for REQ-024 cases.

Structure
REQ-033 The shared package lsu_pkg SHALL hold the FSM state enum and the funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
REQ-034 A combinational sub-module lsu_align SHALL perform lane extraction with extension, and lane merge for stores.

Verification
REQ-035 Memory word 0x100=0x8899AABB; LB addr 0x101 -> rdata=0xFFFFFFAA, done pulses in the 2nd cycle after req, and mem_WE stays 0.
REQ-036 Same word; LHU addr 0x102 -> rdata=0x00008899.
REQ-037 SB addr 0x102, wdata=0x00000012 -> one mem_WE cycle with mem_A=0x100 and mem_WD=0x8812AABB, and done in the 3rd cycle.
REQ-038 SW addr 0x200, wdata=0xDEADBEEF -> a single write of 0xDEADBEEF to 0x200 with no READ state, and done in the 2nd cycle.
REQ-039 LW addr 0x102 -> with LSU_MISALIGN_TRAP_EN: err=done=1 and no memory access; without it: rdata=0x8899AABB.
REQ-040 rst asserted during the READ cycle of SB 0x100 -> IDLE next cycle, busy=0, no write, and the word is unchanged.
